uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
// - Schedules the shared txuart transmitter between two byte sources: CPU output
//   (falling edge of the CPU TX line, byte = {Aval,Bval}) and a debug/status port.
// - Buffers CPU bytes in a small FIFO so back-to-back CPU TX pulses are not lost at 9600 baud.
// - Sits between the cscv2 CPU and txuart in the ULX3S top level, on the 25MHz i_clk domain.
// - Replaces the bare tx_stb edge detector in the top level.
// PARAMETERS
// - DEPTH_LOG2   2   log2 of CPU FIFO depth (default 4 entries).
// PORTS
// - i_clk        in   1   25MHz system clock.
// - i_rst_n      in   1   Asynchronous reset, active low.
// - i_cpu_tx     in   1   CPU TX line; a 1->0 transition requests a send.
// - i_cpu_data   in   8   CPU byte, sampled on the cycle the falling edge is detected.
// - i_dbg_stb    in   1   Debug request; held high until o_dbg_ack.
// - i_dbg_data   in   8   Debug byte; stable while i_dbg_stb is high.
// - o_dbg_ack    out  1   One-cycle pulse: debug byte accepted (issued to the UART).
// - o_tx_stb     out  1   To txuart i_wr; one-cycle pulse.
// - o_tx_data    out  8   To txuart data; valid when o_tx_stb=1.
// - i_tx_busy    in   1   From txuart busy.
// - o_fifo_full  out  1   CPU FIFO holds 2**DEPTH_LOG2 entries.
// - o_drop_cnt   out  8   Count of CPU bytes dropped on a full FIFO; saturates at 255.
// BEHAVIOUR
// - Reset (async, any time): FIFO emptied; o_tx_stb=0, o_tx_data=0, o_dbg_ack=0,
//   o_drop_cnt=0, o_fifo_full=0; edge register old_tx=1; FSM=IDLE; last_grant=DBG.
// - Edge detect: push = (i_cpu_tx==0 && old_tx==1); old_tx <= i_cpu_tx every cycle.
//   Exactly one push per falling edge, however long TX stays low.
// - FIFO push/pop rule: a push is accepted if count<DEPTH or a pop occurs on the same
//   cycle. Otherwise the byte is dropped and o_drop_cnt increments (holds at 255).
//   Simultaneous push+pop on an empty FIFO: the pop is not possible (empty); push is stored.
// - Pointers wrap modulo DEPTH; count is DEPTH_LOG2+1 bits wide.
// - FSM states:
//   IDLE      : if i_tx_busy==0 and a source is pending -> grant, go ISSUE.
//               Arbitration: both pending -> the source opposite last_grant wins
//               (round robin); single pending -> that source.
//   ISSUE     : o_tx_stb=1 for exactly one cycle with o_tx_data=granted byte.
//               CPU grant pops the FIFO on this cycle; DBG grant pulses o_dbg_ack on this cycle.
//               -> WAIT_BUSY.
//   WAIT_BUSY : wait for i_tx_busy==1 -> WAIT_DONE.
//   WAIT_DONE : wait for i_tx_busy==0 -> IDLE.
// - Minimum spacing between o_tx_stb pulses is 3 cycles plus the UART frame time.
// - Latency: for an idle UART, an empty FIFO and no debug request, a CPU falling edge
//   detected in cycle N produces o_tx_stb in cycle N+2. Cycle N+1 is IDLE seeing the
//   non-empty FIFO.
// - Reset while txuart is mid-frame: FSM restarts in IDLE and does not issue until
//   i_tx_busy==0.
// - o_tx_data holds the last issued byte between strobes.
// CONFIGURATION
// - UART_TX_SCHED_CRLF_EN defined: when a CPU byte 0x0A is granted, the FSM first issues
//   0x0D through ISSUE/WAIT_BUSY/WAIT_DONE. It then issues 0x0A without re-arbitrating.
//   The 0x0A pops the FIFO only on its own ISSUE.
// - UART_TX_SCHED_CRLF_EN undefined: bytes are sent verbatim and no extra state exists.
// TESTING
// - Single CPU edge, data 0x5A, UART idle: exactly one o_tx_stb at edge+2 with 0x5A;
//   no second strobe while TX stays low for 4096 cycles.
// - Six CPU edges, 0x01..0x06, spaced 10 cycles, with busy held 100 cycles per byte:
//   UART receives 0x01..0x04 plus the byte that fits after the first pop (0x05);
//   o_drop_cnt=1; o_fifo_full asserts after the 4th buffered byte.
// - Debug 0xAA pending and FIFO holding 0x11,0x22, last_grant=DBG: order is 0x11, 0xAA,
//   0x22; o_dbg_ack pulses once, coincident with the 0xAA strobe.
// - Assert i_rst_n=0 during WAIT_DONE with i_tx_busy=1: all outputs are 0 immediately.
//   After release there is no strobe until busy falls; then queued requests are served fresh.
// - 300 dropped bytes: o_drop_cnt saturates at 255.
// - With UART_TX_SCHED_CRLF_EN defined, CPU byte 0x0A gives strobes 0x0D then 0x0A.
//   Without it, CPU byte 0x0A gives a single 0x0A.

Source files
------------

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// uart_tx_sched : shares one txuart between a CPU byte FIFO and a debug port.
// Option macro  : UART_TX_SCHED_CRLF_EN (expand CPU 0x0A into 0x0D,0x0A)
// Revision      : 1.0
// ============================================================================
module uart_tx_sched #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cpu_tx,
  input  logic [7:0] i_cpu_data,
  input  logic       i_dbg_stb,
  input  logic [7:0] i_dbg_data,
  output logic       o_dbg_ack,
  output logic       o_tx_stb,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_fifo_full,
  output logic [7:0] o_drop_cnt
);

  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_INC = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_INC = (DEPTH_LOG2 + 1)'(1);
  localparam logic [7:0]            LF      = 8'h0A;
  localparam logic [7:0]            CR      = 8'h0D;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                state;
  logic                  old_tx;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  last_grant_cpu;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  cpu_pending;
  logic                  pick_cpu;
  logic                  do_grant;
  logic [7:0]            head;

  assign push        = ~i_cpu_tx & old_tx;
  assign cpu_pending = (count != '0);
  assign head        = mem[rd_ptr];
  // count never exceeds DEPTH, so its MSB alone marks a full FIFO
  assign o_fifo_full = count[DEPTH_LOG2];
  assign push_ok     = push & (~count[DEPTH_LOG2] | pop);

  // Round robin only matters when both sources wait; otherwise the lone one wins.
  assign pick_cpu = cpu_pending & (~i_dbg_stb | ~last_grant_cpu);
  assign do_grant = ~i_tx_busy & (cpu_pending | i_dbg_stb);

`ifdef UART_TX_SCHED_CRLF_EN
  logic cr_phase;
  assign pop = (state == ISSUE) & last_grant_cpu & ~cr_phase;
`else
  assign pop = (state == ISSUE) & last_grant_cpu;
`endif

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_cpu_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      old_tx     <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_drop_cnt <= 8'd0;
    end else begin
      old_tx <= i_cpu_tx;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_INC;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_INC;
        2'b01:   count <= count - CNT_INC;
        default: count <= count;
      endcase
      if (push && !push_ok && (o_drop_cnt != 8'hFF)) begin
        o_drop_cnt <= o_drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      o_tx_stb       <= 1'b0;
      o_tx_data      <= 8'h00;
      o_dbg_ack      <= 1'b0;
      last_grant_cpu <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
      cr_phase       <= 1'b0;
`endif
    end else begin
      o_tx_stb  <= 1'b0;
      o_dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (do_grant) begin
            state          <= ISSUE;
            o_tx_stb       <= 1'b1;
            last_grant_cpu <= pick_cpu;
            if (pick_cpu) begin
`ifdef UART_TX_SCHED_CRLF_EN
              if (head == LF) begin
                o_tx_data <= CR;
                cr_phase  <= 1'b1;
              end else begin
                o_tx_data <= head;
              end
`else
              o_tx_data <= head;
`endif
            end else begin
              o_tx_data <= i_dbg_data;
              o_dbg_ack <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!i_tx_busy) begin
`ifdef UART_TX_SCHED_CRLF_EN
            // The LF follows its CR directly; the grant stays with the CPU.
            if (cr_phase) begin
              cr_phase  <= 1'b0;
              o_tx_stb  <= 1'b1;
              o_tx_data <= LF;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// Bench for uart_tx_sched: cycle vector table plus multi-cycle scenario sequences.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_cpu_tx = 1'b1;
  logic [7:0] i_cpu_data = 8'h00;
  logic       i_dbg_stb = 1'b0;
  logic [7:0] i_dbg_data = 8'h00;
  logic       i_tx_busy = 1'b0;
  logic       o_dbg_ack;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       o_fifo_full;
  logic [7:0] o_drop_cnt;

  uart_tx_sched #(.DEPTH_LOG2(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_cpu_tx    (i_cpu_tx),
    .i_cpu_data  (i_cpu_data),
    .i_dbg_stb   (i_dbg_stb),
    .i_dbg_data  (i_dbg_data),
    .o_dbg_ack   (o_dbg_ack),
    .o_tx_stb    (o_tx_stb),
    .o_tx_data   (o_tx_data),
    .i_tx_busy   (i_tx_busy),
    .o_fifo_full (o_fifo_full),
    .o_drop_cnt  (o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        cpu_tx;
    logic [7:0]  cpu_data;
    logic        dbg_stb;
    logic [7:0]  dbg_data;
    logic        busy;
    logic [18:0] exp;  // {stb, data, ack, full, drop}
  } vec_t;

  vec_t       vecs[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         busy_len = 3;
  int         busy_left = 0;
  int         stb_total = 0;
  int         ack_cnt = 0;
  logic [7:0] ack_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic tx, input logic [7:0] cd, input logic ds,
                     input logic [7:0] dd, input logic b, input logic e_stb,
                     input logic [7:0] e_data, input logic e_ack, input logic e_full,
                     input logic [7:0] e_drop);
    vec_t v;
    v.rst_n = r; v.cpu_tx = tx; v.cpu_data = cd; v.dbg_stb = ds;
    v.dbg_data = dd; v.busy = b;
    v.exp = {e_stb, e_data, e_ack, e_full, e_drop};
    vecs.push_back(v);
  endtask

  // One cycle with a simple txuart model: busy rises after each strobe for busy_len cycles.
  task automatic tick();
    @(negedge clk);
    if (o_dbg_ack) begin
      ack_cnt++;
      ack_data = o_tx_stb ? o_tx_data : 8'hFF;
      i_dbg_stb = 1'b0;
    end
    if (o_tx_stb) begin
      rx_q.push_back(o_tx_data);
      stb_total++;
      busy_left = busy_len;
    end
    i_tx_busy = (busy_left > 0);
    if (busy_left > 0) busy_left--;
  endtask

  task automatic cpu_edge(input logic [7:0] d);
    i_cpu_tx = 1'b0;
    i_cpu_data = d;
    tick();
    i_cpu_tx = 1'b1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_cpu_tx = 1'b1;
    i_dbg_stb = 1'b0;
    i_tx_busy = 1'b0;
    busy_left = 0;
    @(negedge clk);
    check("reset_outputs", {13'd0, o_tx_stb, o_tx_data, o_dbg_ack, o_fifo_full, o_drop_cnt}, 32'd0);
    i_rst_n = 1'b1;
    rx_q.delete();
    ack_cnt = 0;
    stb_total = 0;
    @(negedge clk);
  endtask

  task automatic check_rx(input string name);
    check({name, "_count"}, rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
      check($sformatf("%s_byte%0d", name, k), rx_q[k], exp_q[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    int guard;

    // rst, tx, cdata, dstb, ddata, busy | stb, data, ack, full, drop
    add(0, 1, 8'h00, 0, 8'h00, 0,  0, 8'h00, 0, 0, 8'd0);
    add(1, 1, 8'h00, 0, 8'h00, 0,  0, 8'h00, 0, 0, 8'd0);
    add(1, 1, 8'h00, 1, 8'hC3, 1,  0, 8'h00, 0, 0, 8'd0);  // busy blocks grant
    add(1, 1, 8'h00, 1, 8'hC3, 0,  1, 8'hC3, 1, 0, 8'd0);
    add(1, 1, 8'h00, 0, 8'h00, 0,  0, 8'hC3, 0, 0, 8'd0);
    add(1, 1, 8'h00, 0, 8'h00, 1,  0, 8'hC3, 0, 0, 8'd0);
    add(1, 1, 8'h00, 0, 8'h00, 1,  0, 8'hC3, 0, 0, 8'd0);
    add(1, 1, 8'h00, 0, 8'h00, 0,  0, 8'hC3, 0, 0, 8'd0);
    add(1, 0, 8'h5A, 0, 8'h00, 0,  0, 8'hC3, 0, 0, 8'd0);  // edge detected
    add(1, 0, 8'h00, 0, 8'h00, 0,  1, 8'h5A, 0, 0, 8'd0);  // strobe at edge+2
    add(1, 0, 8'h00, 0, 8'h00, 0,  0, 8'h5A, 0, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 1,  0, 8'h5A, 0, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0,  0, 8'h5A, 0, 0, 8'd0);
    add(1, 0, 8'h00, 0, 8'h00, 0,  0, 8'h5A, 0, 0, 8'd0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      i_rst_n    = vecs[i].rst_n;
      i_cpu_tx   = vecs[i].cpu_tx;
      i_cpu_data = vecs[i].cpu_data;
      i_dbg_stb  = vecs[i].dbg_stb;
      i_dbg_data = vecs[i].dbg_data;
      i_tx_busy  = vecs[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {13'd0, o_tx_stb, o_tx_data, o_dbg_ack, o_fifo_full, o_drop_cnt},
            {13'd0, vecs[i].exp});
    end

    // TX held low: no repeated request
    snap = stb_total;
    repeat (4096) tick();
    check("low_hold_no_strobe", stb_total - snap, 0);
    i_cpu_tx = 1'b1;

    // Burst of six CPU bytes against a slow UART
    do_reset();
    busy_len = 100;
    for (int k = 0; k < 6; k++) begin
      cpu_edge(8'(k + 1));
      if (k == 3) check("full_after_3_buffered", o_fifo_full, 0);
      if (k == 4) check("full_after_4_buffered", o_fifo_full, 1);
      repeat (9) tick();
    end
    repeat (800) tick();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("burst");
    check("burst_drop_cnt", o_drop_cnt, 1);
    check("burst_full_drained", o_fifo_full, 0);

    // Round robin: CPU wins first after a DBG last grant
    do_reset();
    busy_len = 5;
    busy_left = 30;
    i_tx_busy = 1'b1;
    cpu_edge(8'h11);
    tick();
    cpu_edge(8'h22);
    tick();
    i_dbg_data = 8'hAA;
    i_dbg_stb = 1'b1;
    repeat (100) tick();
    exp_q = '{8'h11, 8'hAA, 8'h22};
    check_rx("rr");
    check("rr_ack_count", ack_cnt, 1);
    check("rr_ack_with_strobe", ack_data, 8'hAA);

    // Reset while the UART is mid-frame
    do_reset();
    busy_len = 20;
    cpu_edge(8'h33);
    guard = 0;
    while (rx_q.size() == 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("midframe_first_strobe", rx_q.size(), 1);
    repeat (5) tick();
    check("midframe_busy_high", i_tx_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          {13'd0, o_tx_stb, o_tx_data, o_dbg_ack, o_fifo_full, o_drop_cnt}, 32'd0);
    tick();
    i_rst_n = 1'b1;
    cpu_edge(8'h44);
    snap = stb_total;
    guard = 0;
    while (i_tx_busy && guard < 100) begin
      tick();
      guard++;
    end
    check("midframe_no_strobe_while_busy", stb_total - snap, 0);
    check("midframe_busy_fell", i_tx_busy, 0);
    repeat (40) tick();
    exp_q = '{8'h33, 8'h44};
    check_rx("midframe");

    // Drop counter saturation
    do_reset();
    busy_len = 3;
    busy_left = 2000;
    i_tx_busy = 1'b1;
    for (int i = 0; i < 304; i++) begin
      cpu_edge(i[7:0]);
      tick();
      if (i == 203) check("drop_cnt_200", o_drop_cnt, 200);
    end
    check("drop_full", o_fifo_full, 1);
    check("drop_cnt_saturated", o_drop_cnt, 255);

    // Line-feed handling
    do_reset();
    busy_len = 4;
    cpu_edge(8'h0A);
    tick();
    cpu_edge(8'h41);
    repeat (60) tick();
`ifdef UART_TX_SCHED_CRLF_EN
    exp_q = '{8'h0D, 8'h0A, 8'h41};
`else
    exp_q = '{8'h0A, 8'h41};
`endif
    check_rx("newline");
    check("newline_no_drop", o_drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
